// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches 12-bit instructions, drives an external ALU and branches on its captured flags.
// Define ALU_SEQ_TRACE_EN to add the retired-instruction trace ports (oTrValid/oTrPc/oTrResult/oTrFlags).
module alu_sequencer #(
  parameter int ALU_LAT   = 1,
  parameter int MAX_STEPS = 255,
  parameter int STEP_W    = 8
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iProgWe,
  input  logic [3:0]  iProgAddr,
  input  logic [11:0] iProgData,
  input  logic        iStart,
  input  logic [1:0]  iRdSel,
  output logic [3:0]  oRdData,
  output logic [3:0]  oA,
  output logic [3:0]  oB,
  output logic [3:0]  oOpCode,
  input  logic [3:0]  iResult,
  input  logic [4:0]  iStatus,
  output logic [4:0]  oFlags,
  output logic [3:0]  oPc,
  output logic        oBusy,
  output logic        oDone,
`ifdef ALU_SEQ_TRACE_EN
  output logic        oTrValid,
  output logic [3:0]  oTrPc,
  output logic [3:0]  oTrResult,
  output logic [4:0]  oTrFlags,
`endif
  output logic        oErr
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                         S_WAIT = 3'd3, S_CAPTURE = 3'd4, S_DONE = 3'd5;
  localparam int CNT_W = $clog2(ALU_LAT + 1);
  logic [2:0]        r_state;
  logic [11:0]       r_mem [16];
  logic [11:0]       r_ir;
  logic [3:0]        r_pc;
  logic [STEP_W-1:0] r_step;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_rf [4];
  logic [3:0]        r_res;
  logic [4:0]        r_stat;
  logic [3:0]        r_a, r_b, r_op;
  logic [4:0]        r_flags;
  logic              r_err;
  logic [3:0]        w_op;
  logic [1:0]        w_rd, w_ra, w_rb;
  logic [2:0]        w_cond;
  logic [7:0]        w_flags8;
  logic              w_is_alu, w_is_br, w_halt, w_taken, w_last;
  assign w_op     = r_ir[11:8];
  assign w_rd     = r_ir[7:6];
  assign w_ra     = r_ir[5:4];
  assign w_rb     = r_ir[3:2];
  assign w_cond   = r_ir[7:5];
  assign w_flags8 = {3'b000, r_flags};
  assign w_is_br  = w_op == 4'hF;
  assign w_is_alu = w_op != 4'h0 && !w_is_br;
  assign w_halt   = w_is_br && w_cond == 3'd6;
  // cond 5 and 6 index the zero padding, so they never count as taken
  assign w_taken  = w_is_br && (w_cond == 3'd7 || (w_flags8[w_cond] ^ r_ir[4]) && w_cond < 3'd5);
  assign w_last   = r_pc == 4'hF;
  assign oRdData  = r_rf[iRdSel];
  assign oA       = r_a;
  assign oB       = r_b;
  assign oOpCode  = r_op;
  assign oFlags   = r_flags;
  assign oPc      = r_pc;
  assign oErr     = r_err;
  assign oBusy    = r_state != S_IDLE && r_state != S_DONE;
  assign oDone    = r_state == S_DONE;
  always_ff @(posedge iClk)
    if (iProgWe && r_state == S_IDLE) r_mem[iProgAddr] <= iProgData;
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_pc    <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_stat  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (iStart) begin
          r_state <= S_FETCH;
          r_pc    <= '0;
          r_step  <= '0;
          r_err   <= 1'b0;
        end
        S_FETCH: if (r_step == STEP_W'(MAX_STEPS)) begin
          r_state <= S_DONE;
          r_err   <= 1'b1;
        end else begin
          r_ir    <= r_mem[r_pc];
          r_step  <= r_step + STEP_W'(1);
          r_state <= S_EXEC;
        end
        S_EXEC: if (w_is_alu) begin
          r_a     <= r_rf[w_ra];
          r_b     <= r_rf[w_rb];
          r_op    <= w_op;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end else begin
          if (w_op == 4'h0) r_rf[w_rd] <= r_ir[3:0];
          if (w_halt) r_state <= S_DONE;
          else if (w_taken) begin
            r_pc    <= r_ir[3:0];
            r_state <= S_FETCH;
          end else if (w_last) r_state <= S_DONE;
          else begin
            r_pc    <= r_pc + 4'd1;
            r_state <= S_FETCH;
          end
        end
        S_WAIT: if (r_cnt == CNT_W'(ALU_LAT - 1)) begin
          r_res   <= iResult;
          r_stat  <= iStatus;
          r_state <= S_CAPTURE;
        end else r_cnt <= r_cnt + CNT_W'(1);
        S_CAPTURE: begin
          r_rf[w_rd] <= r_res;
          r_flags    <= r_stat;
          r_op       <= 4'h0;
          r_state    <= w_last ? S_DONE : S_FETCH;
          if (!w_last) r_pc <= r_pc + 4'd1;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef ALU_SEQ_TRACE_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oTrValid  <= 1'b0;
      oTrPc     <= '0;
      oTrResult <= '0;
      oTrFlags  <= '0;
    end else begin
      oTrValid <= r_state == S_CAPTURE;
      if (r_state == S_CAPTURE) begin
        oTrPc     <= r_pc;
        oTrResult <= r_res;
        oTrFlags  <= r_stat;
      end
    end
  end
`endif
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Micro-sequencer that drives the 4-bit ALU from the other side of its interface.
- Fetches 12-bit instructions from a small loadable program store.
- Issues operands and opCode to the ALU, then captures the result into a 4-entry register file and the 5-bit status into a flag register.
- Resolves conditional branches on the captured flags; gives the ALU a self-running test/driver harness.

Parameters:
- ALU_LAT, 1, cycles from operand issue to result/status sampling (>=1).
- MAX_STEPS, 255, instruction budget per run before forced error stop.
- STEP_W, 8, width of step counter (must hold MAX_STEPS).

Ports:
- iClk  in  1  clock
- iRst_n  in  1  asynchronous active-low reset
- iProgWe  in  1  program store write strobe (honoured only when idle)
- iProgAddr  in  4  program write address
- iProgData  in  12  program write data
- iStart  in  1  start-run pulse, PC=0
- iRdSel  in  2  register file read select
- oRdData  out  4  register file read data (combinational on iRdSel)
- oA  out  4  ALU operand A (registered)
- oB  out  4  ALU operand B (registered)
- oOpCode  out  4  ALU opcode (registered)
- iResult  in  4  ALU result
- iStatus  in  5  ALU status {P,Z,C,S,O} = bits [4:0]
- oFlags  out  5  last captured status
- oPc  out  4  current PC
- oBusy  out  1  run in progress
- oDone  out  1  one-cycle pulse at run end
- oErr  out  1  sticky until next iStart: step budget exhausted

Behaviour:
- Reset:
  - All outputs 0, state IDLE, register file and flags cleared.
  - Program store not cleared.
- Instruction decode, op = [11:8]:
  - op 0001..1110 (ALU op): rd=[7:6], ra=[5:4], rb=[3:2].
  - op 0000 (LDI): rd=[7:6], imm=[3:0]; rd<=imm; flags unchanged.
  - op 1111 (BR): cond=[7:5], inv=[4], target=[3:0].
    - cond 0..4 selects flag O,S,C,Z,P; taken if flag^inv==1.
    - cond 7 = always taken.
    - cond 6 = HALT.
    - cond 5 = NOP (never taken).
- FSM states: IDLE, FETCH, EXEC, WAIT, CAPTURE, DONE.
  - IDLE: oBusy=0. iStart -> FETCH, PC=0, step=0, oErr=0.
  - FETCH: IR<=mem[PC]; step+1; if step==MAX_STEPS -> DONE with oErr=1.
  - EXEC, ALU op: oA<=reg[ra], oB<=reg[rb], oOpCode<=op -> WAIT.
  - EXEC, LDI/BR: resolve in place -> next PC. HALT -> DONE.
  - WAIT: hold oA/oB/oOpCode for ALU_LAT cycles; sample on last cycle -> CAPTURE.
  - CAPTURE: reg[rd]<=iResult, oFlags<=iStatus, oOpCode<=0000 -> next PC.
  - Next PC: branch taken -> target.
    - Else if PC==15 -> DONE (end of program; no wrap).
    - Else PC+1 -> FETCH.
  - DONE: oDone=1 for one cycle, oBusy=0 -> IDLE. Registers and flags retained for readout.
- Latency: ALU instruction = 3+ALU_LAT cycles (FETCH, EXEC, WAIT xALU_LAT, CAPTURE); LDI/BR = 2 cycles.
- oBusy=1 in all states except IDLE and DONE.
- Boundary conditions:
  - iStart while busy: ignored.
  - iProgWe while busy: ignored.
  - iStart and iProgWe in same idle cycle: write lands; first FETCH sees new data.
  - rd==ra/rb: operands read at EXEC, write at CAPTURE; no hazard.
  - Reset mid-run: immediate return to IDLE, outputs cleared, no oDone.

Optional Feature:
- Macro: ALU_SEQ_TRACE_EN.
- Defined: adds ports oTrValid (1), oTrPc (4), oTrResult (4), oTrFlags (5). oTrValid pulses one cycle per retired ALU instruction (cycle after CAPTURE), carrying its PC, result and status.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Load LDI r0,5; LDI r1,3; ADD(0001) r2=r0,r1; BR HALT. Start with bench ALU returning 8/5'b10010 -> r2=8, oFlags=10010, oDone after 2+2+4+2=10 cycles, oErr=0.
- SUB r0,r0 with model status Z=1, then BR cond=3 inv=0 target=9; mem[9]=HALT -> oPc reaches 9, PC 2..8 never fetched.
- Same branch with inv=1 -> falls through to PC+1; no HALT at end -> DONE after PC 15 executes.
- mem[0]=BR always target 0, MAX_STEPS=255 -> oErr=1, oDone pulse after the 255th fetch.
- ALU_LAT=3: oA/oB/oOpCode stable 3 cycles, iResult changed before last WAIT cycle ignored, value on last WAIT cycle captured.
- Assert iRst_n low during WAIT -> outputs 0 same cycle, no oDone. Reissue iStart -> program runs from PC 0 with intact program store.
